// File: rtl/mnist_img_loader.sv
// MNIST BNN input image loader: packs pixel beats into a 28x28 binary buffer and
// serves one row per cycle. Define IMG_LOADER_BINARIZE_EN for 1-pixel grayscale beats.
module mnist_img_loader #(
  parameter int unsigned IMG_W = 28,
  parameter int unsigned IMG_H = 28
`ifdef IMG_LOADER_BINARIZE_EN
  ,
  parameter int unsigned THRESH = 128
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic [4:0]       rd_row,
  output logic [IMG_W-1:0] rd_data,
  output logic             load_done,
  output logic             busy,
  output logic [9:0]       pix_count
);

  localparam int unsigned PIX_N = IMG_W * IMG_H;
  localparam int unsigned CNT_W = 10;
`ifdef IMG_LOADER_BINARIZE_EN
  localparam int unsigned BEAT_W = 1;
`else
  localparam int unsigned BEAT_W = 8;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PIX_N-1:0]   r_buf;
  logic [CNT_W-1:0]   r_pix_count;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_wr_en;
  logic [BEAT_W-1:0]  w_beat;
  logic               r_busy;
  logic               r_load_done;
  logic               w_row_ok;
  logic [CNT_W-1:0]   w_base;

`ifdef IMG_LOADER_BINARIZE_EN
  assign w_beat = BEAT_W'(32'(data_in) >= THRESH);
`else
  assign w_beat = data_in;
`endif

  assign w_cnt_inc = r_pix_count + CNT_W'(BEAT_W);

  // Next-state, write enable and counter update
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_pix_count;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_en) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (!load_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (data_valid) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(PIX_N)) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!load_en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pix_count <= '0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_count <= w_cnt_nxt;
      r_busy      <= (w_state_nxt == S_LOAD);
      r_load_done <= (w_state_nxt == S_DONE);
    end
  end

  // Image buffer: pixel p = row*IMG_W + col at bit p, overwritten in place per load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf <= '0;
    end else if (w_wr_en) begin
      r_buf[r_pix_count +: BEAT_W] <= w_beat;
    end
  end

  // Combinational row read; rows past the image read as zero
  assign w_row_ok = (32'(rd_row) < IMG_H);
  assign w_base   = w_row_ok ? CNT_W'(32'(rd_row) * IMG_W) : '0;
  assign rd_data  = w_row_ok ? r_buf[w_base +: IMG_W] : '0;

  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign pix_count = r_pix_count;

endmodule

// File: tb/tb_mnist_img_loader.sv
// Directed self-checking bench for mnist_img_loader (packed and binarize builds).
module tb_mnist_img_loader;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [4:0]  rd_row;
  logic [27:0] rd_data;
  logic        load_done;
  logic        busy;
  logic [9:0]  pix_count;

  int n_tests;
  int n_fail;

  mnist_img_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .data_in    (data_in),
    .data_valid (data_valid),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .load_done  (load_done),
    .busy       (busy),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string tag, input int r, input logic [27:0] exp);
    rd_row = 5'(r);
    #1;
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    logic done_seen;
    clk        = 1'b0;
    rst_n      = 1'b0;
    load_en    = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    rd_row     = 5'd0;
    n_tests    = 0;
    n_fail     = 0;

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(pix_count), 32'd0);
    for (int r = 0; r < 28; r++) check_row("rst_row", r, 28'h0);

    // Beat presented on the entry edge is ignored
    load_en    = 1'b1;
    data_valid = 1'b1;
    data_in    = 8'hFF;
    tick();
    check("entry_busy", 32'(busy), 32'd1);
    check("entry_cnt", 32'(pix_count), 32'd0);
    check_row("entry_nowrite", 0, 28'h0);

`ifndef IMG_LOADER_BINARIZE_EN
    // Packed full load of 0xA5
    data_in = 8'hA5;
    repeat (97) tick();
    check("full_pre_done", 32'(load_done), 32'd0);
    check("full_pre_cnt", 32'(pix_count), 32'd776);
    tick();
    check("full_done", 32'(load_done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_cnt", 32'(pix_count), 32'd784);
    data_valid = 1'b0;
    check_row("full_row0", 0, 28'h5A5A5A5);
    check_row("full_row1", 1, 28'hA5A5A5A);
    check_row("full_row2", 2, 28'h5A5A5A5);
    check_row("full_row27", 27, 28'hA5A5A5A);

    // Data ignored in DONE
    data_in    = 8'hFF;
    data_valid = 1'b1;
    repeat (10) tick();
    check("done_cnt_hold", 32'(pix_count), 32'd784);
    check("done_still", 32'(load_done), 32'd1);
    check_row("done_row0", 0, 28'h5A5A5A5);
    check_row("done_row27", 27, 28'hA5A5A5A);
    data_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    check("exit_done", 32'(load_done), 32'd0);
    check("exit_busy", 32'(busy), 32'd0);

    // Out-of-range rows
    check_row("row28", 28, 28'h0);
    check_row("row31", 31, 28'h0);

    // Abort after 50 beats of 0x3C
    load_en = 1'b1;
    tick();
    data_in    = 8'h3C;
    data_valid = 1'b1;
    done_seen  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (load_done) done_seen = 1'b1;
    end
    check("abort_pre_cnt", 32'(pix_count), 32'd400);
    check("abort_pre_busy", 32'(busy), 32'd1);
    load_en = 1'b0;
    tick();
    if (load_done) done_seen = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(pix_count), 32'd0);
    check("abort_done_seen", 32'(done_seen), 32'd0);
    check_row("abort_row0", 0, 28'hC3C3C3C);
    check_row("abort_row13", 13, 28'h3C3C3C3);
    check_row("abort_row14", 14, 28'h5A5A53C);
    data_valid = 1'b0;
    tick();

    // Abort coincident with the final beat
    load_en = 1'b1;
    tick();
    data_in    = 8'h00;
    data_valid = 1'b1;
    repeat (97) tick();
    load_en = 1'b0;
    tick();
    check("lastabort_done", 32'(load_done), 32'd0);
    check("lastabort_busy", 32'(busy), 32'd0);
    check("lastabort_cnt", 32'(pix_count), 32'd0);
    check_row("lastabort_row27", 27, 28'hA500000);
    data_valid = 1'b0;
    tick();
`else
    // Binarize: alternate 127 / 128 over 784 beats
    for (int p = 0; p < 783; p++) begin
      data_in = (p % 2 == 1) ? 8'd128 : 8'd127;
      tick();
    end
    check("bin_pre_done", 32'(load_done), 32'd0);
    check("bin_pre_cnt", 32'(pix_count), 32'd783);
    data_in = 8'd128;
    tick();
    check("bin_done", 32'(load_done), 32'd1);
    check("bin_cnt", 32'(pix_count), 32'd784);
    data_valid = 1'b0;
    for (int r = 0; r < 28; r++) check_row("bin_row", r, 28'hAAAAAAA);
    check_row("bin_row28", 28, 28'h0);
    check_row("bin_row31", 31, 28'h0);
    load_en = 1'b0;
    tick();
    check("bin_exit_done", 32'(load_done), 32'd0);
`endif

    // Asynchronous reset mid-load
    load_en = 1'b1;
    tick();
    data_in    = 8'hFF;
    data_valid = 1'b1;
    repeat (5) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_done", 32'(load_done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt", 32'(pix_count), 32'd0);
    for (int r = 0; r < 28; r++) check_row("arst_row", r, 28'h0);
    data_valid = 1'b0;
    load_en    = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mnist_img_loader.md
# mnist_img_loader

Input image loader for the MNIST BNN; upstream of the layer-1 engine and the source of the top FSM's `load_done`. While the FSM is in its load state, it accepts pixel beats from the chip's input bus and packs them into a 28×28 binary image buffer. When the last pixel is captured it raises `load_done`. It serves one 28-bit image row per cycle to the layer-1 stage through a combinational read port.

## Interface
- `IMG_W`, default 28: pixels per row.
- `IMG_H`, default 28: rows per image.
- `THRESH`, default 128: binarization threshold; used only with `IMG_LOADER_BINARIZE_EN`.

- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset. One clock; asynchronous, active-low.
- `load_en`  in  1: high while the top FSM is in its load state.
- `data_in`  in  8: pixel beat.
- `data_valid`  in  1: `data_in` is valid this cycle.
- `rd_row`  in  5: row select for the read port.
- `rd_data`  out  28: row `rd_row`. Bit c is column c.
- `load_done`  out  1: image complete; goes to the FSM `load_done` input.
- `busy`  out  1: in LOAD state.
- `pix_count`  out  10: pixels captured in the current load.

## Operation
- Buffer: a flat 784-bit vector. Pixel p = row·28 + col sits at bit p.
- Packed mode (default): each beat carries 8 pixels. `data_in[i]` is pixel 8k+i for beat k. A full image is 98 beats, so beats span row boundaries.
- States and transitions:
  - IDLE → LOAD when `load_en` = 1. The counter clears on entry.
  - LOAD: every cycle with `data_valid` = 1 writes one beat and increments `pix_count` by 8.
  - LOAD → DONE on the final beat (`pix_count` reaches 784).
  - LOAD → IDLE if `load_en` = 0 (abort). Partial contents are kept; `load_done` stays 0; `pix_count` clears.
  - DONE → IDLE when `load_en` = 0.
- `data_valid` is ignored in IDLE and in DONE. No extra writes happen, and `pix_count` holds at 784 in DONE.
- A new load overwrites the buffer in place. There is no clear between images.
- The buffer is retained in IDLE and DONE, which is what the layer-1 stage reads.
- Read port: `rd_data` = bits [28·r+27 : 28·r] for r = `rd_row`. When `rd_row` ≥ 28, `rd_data` = 0.
- Outputs: `busy` = (state == LOAD); `load_done` = (state == DONE).

## Timing
- Reset values: state IDLE, buffer all 0, `pix_count` 0, `load_done` 0, `busy` 0, `rd_data` = 0 for any row.
- Reset is asynchronous. Asserting it mid-load returns the block to IDLE immediately and clears the buffer.
- Entering LOAD takes effect at edge E, the first edge where `load_en` is sampled high. A beat presented at edge E is ignored; the first beat is accepted at edge E+1.
- The final beat is captured at edge N. `load_done` and `busy` = 0 are visible after edge N, so the latency is 1 edge.
- `rd_data` reflects a written beat right after its capturing edge. The read path from `rd_row` to `rd_data` is combinational, with zero cycles latency.
- If `load_en` falls in the same cycle as the final beat, the abort wins: no write, return to IDLE, `load_done` stays 0.
- Back-to-back beats are accepted every cycle. There is no backpressure.

## Configuration
- `IMG_LOADER_BINARIZE_EN` defined:
  - Each beat is one 8-bit grayscale pixel. The stored bit is (`data_in` ≥ `THRESH`).
  - `pix_count` increments by 1, and a full image is 784 beats.
- Not defined: packed mode as described above; `THRESH` is unused.

## Test plan
- Reset: assert `rst_n` = 0 mid-load → `load_done` = 0, `busy` = 0, `pix_count` = 0, and `rd_data` = 0 for rows 0–27.
- Packed full load: 98 beats of 0xA5 on consecutive cycles → `load_done` = 1 one edge after the last beat. Row 0 reads 0x5A5A5A5, row 1 reads 0xA5A5A5A.
- Abort: drop `load_en` after 50 beats → IDLE, `pix_count` = 0, `load_done` never asserted. Beats 0–49 remain readable.
- Ignored data: in DONE, drive 10 beats of 0xFF → buffer unchanged, `pix_count` stays 784. Dropping `load_en` → `load_done` = 0 next edge.
- Boundary: `rd_row` = 28 and `rd_row` = 31 → `rd_data` = 0. A valid beat on the edge `load_en` first rises is not written.
- Binarize build (`IMG_LOADER_BINARIZE_EN`, `THRESH` = 128): alternate pixels 127 and 128 over 784 beats → each row reads 0xAAAAAAA, and `load_done` rises after beat 784.
